// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control/status bundle between the multi-cycle sequencer and its datapath/memory.
// master = sequencer side (mc_ctrl), slave = datapath/memory side.
interface mc_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] instr;
    logic                  EQ;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  MemWrite;
    logic                  AdrSrc;
    logic                  IRWrite;
    logic                  PCWrite;
    logic                  RegWrite;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ALUctrl;
    logic [1:0]            ResultSrc;
    logic [1:0]            ImmSrc;
    logic [3:0]            state;

    modport master (
        input  instr, EQ, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUctrl, ResultSrc, ImmSrc, state
    );

    modport slave (
        output instr, EQ, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUctrl, ResultSrc, ImmSrc, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the RV32I-subset datapath (shared ALU and memory port).
// Optional: define ILLEGAL_TRAP_EN to park illegal instructions in HALT instead of retiring them as NOPs.
module mc_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_if.master     bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0]            r_state;
    logic [3:0]            w_next;
    logic [DATA_WIDTH-1:0] w_instr;
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic                  w_f3Alu;
    logic                  w_legal;
    logic                  w_unused;
    logic [2:0]            w_execOp;

    logic       w_memReq, w_memWrite, w_adrSrc, w_irWrite, w_pcWrite, w_regWrite;
    logic [1:0] w_aluSrcA, w_aluSrcB, w_resultSrc, w_immSrc;
    logic [2:0] w_aluCtrl;

    assign w_instr  = bus.instr;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_funct7 = w_instr[31:25];
    assign w_unused = ^w_instr;
    assign w_f3Alu  = (w_funct3 == 3'b000) || (w_funct3 == 3'b010) ||
                      (w_funct3 == 3'b110) || (w_funct3 == 3'b111);

    // Legality is resolved once in DECODE so later states can trust the fields.
    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OP_LOAD, OP_STORE: w_legal = (w_funct3 == 3'b010);
            OP_R:   w_legal = w_f3Alu && ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));
            OP_I:   w_legal = w_f3Alu;
            OP_BR:  w_legal = (w_funct3[2:1] == 2'b00);
            OP_JAL: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_execOp = ALU_ADD;
        case (w_funct3)
            3'b000:  w_execOp = ((r_state == S_EXECR) && w_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  w_execOp = ALU_SLT;
            3'b110:  w_execOp = ALU_OR;
            3'b111:  w_execOp = ALU_AND;
            default: w_execOp = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_memReq    = 1'b0;
        w_memWrite  = 1'b0;
        w_adrSrc    = 1'b0;
        w_irWrite   = 1'b0;
        w_pcWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_aluSrcA   = 2'b00;
        w_aluSrcB   = 2'b00;
        w_aluCtrl   = ALU_ADD;
        w_resultSrc = 2'b00;
        w_immSrc    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memReq = 1'b1;
                if (bus.mem_ready) begin
                    w_irWrite   = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_aluSrcB   = 2'b10;
                    w_resultSrc = 2'b10;
                    w_next      = S_DECODE;
                end
            end
            S_DECODE: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b01;
                w_immSrc  = (w_opcode == OP_JAL) ? 2'b11 : 2'b10;
                if (!w_legal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_HALT;
`else
                    w_next = S_FETCH;
`endif
                end else begin
                    case (w_opcode)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_R:    w_next = S_EXECR;
                        OP_I:    w_next = S_EXECI;
                        OP_BR:   w_next = S_BRANCH;
                        default: w_next = S_JAL;
                    endcase
                end
            end
            S_MEMADR: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_immSrc  = w_opcode[5] ? 2'b01 : 2'b00;
                w_next    = w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_memReq = 1'b1;
                w_adrSrc = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultSrc = 2'b01;
                w_regWrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_memReq   = 1'b1;
                w_adrSrc   = 1'b1;
                w_memWrite = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_aluCtrl = w_execOp;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_aluSrcA = 2'b10;
                w_aluCtrl = ALU_SUB;
                w_pcWrite = w_funct3[0] ? ~bus.EQ : bus.EQ;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                w_pcWrite = 1'b1;
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b10;
                w_next    = S_ALUWB;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase

        // Reset wins over everything so an abandoned instruction cannot write.
        if (rst) begin
            w_memReq    = 1'b0;
            w_memWrite  = 1'b0;
            w_adrSrc    = 1'b0;
            w_irWrite   = 1'b0;
            w_pcWrite   = 1'b0;
            w_regWrite  = 1'b0;
            w_aluSrcA   = 2'b00;
            w_aluSrcB   = 2'b00;
            w_aluCtrl   = ALU_ADD;
            w_resultSrc = 2'b00;
            w_immSrc    = 2'b00;
        end
    end

    assign bus.mem_req   = w_memReq;
    assign bus.MemWrite  = w_memWrite;
    assign bus.AdrSrc    = w_adrSrc;
    assign bus.IRWrite   = w_irWrite;
    assign bus.PCWrite   = w_pcWrite;
    assign bus.RegWrite  = w_regWrite;
    assign bus.ALUSrcA   = w_aluSrcA;
    assign bus.ALUSrcB   = w_aluSrcB;
    assign bus.ALUctrl   = w_aluCtrl;
    assign bus.ResultSrc = w_resultSrc;
    assign bus.ImmSrc    = w_immSrc;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl; per-cycle output vectors compared against an instruction-level model.
`timescale 1ns/1ps
module tb_mc_ctrl;
    localparam int DATA_WIDTH = 32;

    localparam int K_LW  = 0;
    localparam int K_SW  = 1;
    localparam int K_R   = 2;
    localparam int K_I   = 3;
    localparam int K_BR  = 4;
    localparam int K_JAL = 5;
    localparam int K_ILL = 6;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluCtrl;
        logic [1:0] resultSrc;
        logic [1:0] immSrc;
        logic [3:0] state;
    } outVec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        eq;
        int          fetchWaits;
        int          memWaits;
        int          expCycles;
    } vector_t;

    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;
    int   phaseQ[$];
    vector_t vectors[$];
    outVec_t dutOut;

    mc_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) bus();

    mc_ctrl #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign dutOut = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                     bus.ALUSrcA, bus.ALUSrcB, bus.ALUctrl, bus.ResultSrc, bus.ImmSrc, bus.state};

    // Instruction class derived straight from the RV32I field rules.
    function automatic int kindOf(logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit aluF3 = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        if (op == 7'h03 && f3 == 3'd2) return K_LW;
        if (op == 7'h23 && f3 == 3'd2) return K_SW;
        if (op == 7'h33 && aluF3 && (f7 == 7'h00 || f7 == 7'h20)) return K_R;
        if (op == 7'h13 && aluF3) return K_I;
        if (op == 7'h63 && f3 <= 3'd1) return K_BR;
        if (op == 7'h6F) return K_JAL;
        return K_ILL;
    endfunction

    function automatic logic [2:0] aluOf(logic [2:0] f3, bit isSub);
        case (f3)
            3'd0:    return isSub ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word for one phase of an instruction.
    function automatic outVec_t expOut(int st, logic [31:0] ins, logic eq, logic rdy);
        outVec_t o = '0;
        o.state = 4'(st);
        case (st)
            0: begin
                o.memReq = 1'b1;
                if (rdy) begin
                    o.irWrite = 1'b1; o.pcWrite = 1'b1; o.aluSrcB = 2'b10; o.resultSrc = 2'b10;
                end
            end
            1: begin
                o.aluSrcA = 2'b01; o.aluSrcB = 2'b01;
                o.immSrc  = (ins[6:0] == 7'h6F) ? 2'b11 : 2'b10;
            end
            2: begin
                o.aluSrcA = 2'b10; o.aluSrcB = 2'b01;
                o.immSrc  = (ins[6:0] == 7'h23) ? 2'b01 : 2'b00;
            end
            3: begin o.memReq = 1'b1; o.adrSrc = 1'b1; end
            4: begin o.resultSrc = 2'b01; o.regWrite = 1'b1; end
            5: begin o.memReq = 1'b1; o.adrSrc = 1'b1; o.memWrite = 1'b1; end
            6, 7: begin
                o.aluSrcA = 2'b10;
                o.aluSrcB = (st == 7) ? 2'b01 : 2'b00;
                o.aluCtrl = aluOf(ins[14:12], (st == 6) && ins[30]);
            end
            8: o.regWrite = 1'b1;
            9: begin
                o.aluSrcA = 2'b10; o.aluCtrl = 3'b001;
                o.pcWrite = (ins[14:12] == 3'd0) ? eq : ~eq;
            end
            10: begin o.pcWrite = 1'b1; o.aluSrcA = 2'b01; o.aluSrcB = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic buildPhases(input logic [31:0] ins);
        phaseQ.delete();
        case (kindOf(ins))
            K_LW:    phaseQ = '{0, 1, 2, 3, 4};
            K_SW:    phaseQ = '{0, 1, 2, 5};
            K_R:     phaseQ = '{0, 1, 6, 8};
            K_I:     phaseQ = '{0, 1, 7, 8};
            K_BR:    phaseQ = '{0, 1, 9};
            K_JAL:   phaseQ = '{0, 1, 10, 8};
            default: phaseQ = '{0, 1};
        endcase
    endtask

    task automatic checkOutput(input string name, input outVec_t exp);
        compared++;
        if (dutOut !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %06h (state %0d) required %06h (state %0d)",
                     name, dutOut, dutOut.state, exp, exp.state);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Runs one instruction from FETCH, checking every cycle; called at a negedge.
    task automatic applyStimulus(input string name, input logic [31:0] ins, input logic eq,
                                 input int fetchWaits, input int memWaits, output int cycles);
        int st;
        int waits;
        cycles = 0;
        buildPhases(ins);
        bus.instr = ins;
        bus.EQ    = eq;
        for (int i = 0; i < phaseQ.size(); i++) begin
            st = phaseQ[i];
            if (st == 0 || st == 3 || st == 5) begin
                waits = (st == 0) ? fetchWaits : memWaits;
                for (int w = 0; w < waits; w++) begin
                    bus.mem_ready = 1'b0;
                    #1 checkOutput($sformatf("%s ph%0d wait%0d", name, i, w), expOut(st, ins, eq, 1'b0));
                    @(negedge clk);
                    cycles++;
                end
                bus.mem_ready = 1'b1;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1 checkOutput($sformatf("%s ph%0d", name, i), expOut(st, ins, eq, bus.mem_ready));
            @(negedge clk);
            cycles++;
        end
    endtask

    function automatic logic [2:0] randAluF3();
        case ($urandom_range(0, 3))
            0:       return 3'b000;
            1:       return 3'b010;
            2:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] randInstr(int kind);
        logic [31:0] r = $urandom;
        case (kind)
            K_LW:  begin r[6:0] = 7'h03; r[14:12] = 3'b010; end
            K_SW:  begin r[6:0] = 7'h23; r[14:12] = 3'b010; end
            K_R:   begin
                r[6:0] = 7'h33; r[14:12] = randAluF3();
                r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            K_I:   begin r[6:0] = 7'h13; r[14:12] = randAluF3(); end
            K_BR:  begin r[6:0] = 7'h63; r[14:12] = {2'b00, 1'($urandom_range(0, 1))}; end
            K_JAL: r[6:0] = 7'h6F;
            default: begin
                if ($urandom_range(0, 1) == 1) r[6:0] = 7'h7F;
                else begin r[6:0] = 7'h03; r[14:12] = 3'b000; end
            end
        endcase
        return r;
    endfunction

    initial begin
        int cycles;
        int kind;
        logic [31:0] lwInstr;
        lwInstr = 32'h0000A303;

        vectors.push_back('{"addi_x5",  32'h00700293, 1'b0, 0, 0, 4});
        vectors.push_back('{"lw_waits", 32'h0000A303, 1'b0, 2, 3, 10});
        vectors.push_back('{"beq_tkn",  32'h00208063, 1'b1, 0, 0, 3});
        vectors.push_back('{"beq_not",  32'h00208063, 1'b0, 0, 0, 3});
        vectors.push_back('{"bne_eq",   32'h00209063, 1'b1, 0, 0, 3});
        vectors.push_back('{"bne_ne",   32'h00209063, 1'b0, 0, 0, 3});
        vectors.push_back('{"sw_wait4", 32'h0020A023, 1'b0, 0, 4, 8});
        vectors.push_back('{"add",      32'h002081B3, 1'b0, 0, 0, 4});
        vectors.push_back('{"sub",      32'h402081B3, 1'b0, 0, 0, 4});
        vectors.push_back('{"slt",      32'h0020A1B3, 1'b0, 0, 0, 4});
        vectors.push_back('{"or",       32'h0020E1B3, 1'b0, 0, 0, 4});
        vectors.push_back('{"and",      32'h0020F1B3, 1'b0, 0, 0, 4});
        vectors.push_back('{"addi_b30", 32'h40000093, 1'b0, 0, 0, 4});
        vectors.push_back('{"jal_w1",   32'h000000EF, 1'b0, 1, 0, 5});
`ifndef ILLEGAL_TRAP_EN
        vectors.push_back('{"ill_7f",   32'h0000007F, 1'b0, 0, 0, 2});
        vectors.push_back('{"ill_lwf3", 32'h00008303, 1'b0, 0, 0, 2});
        vectors.push_back('{"ill_f7",   32'h022081B3, 1'b0, 0, 0, 2});
        vectors.push_back('{"ill_brf3", 32'h0020A063, 1'b0, 0, 0, 2});
`endif

        rst = 1'b1;
        bus.instr = '0;
        bus.EQ = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1 checkOutput("reset_hold", '0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1 checkOutput("first_fetch_req", expOut(0, 32'h0, 1'b0, 1'b0));

        foreach (vectors[v]) begin
            applyStimulus(vectors[v].name, vectors[v].instr, vectors[v].eq,
                          vectors[v].fetchWaits, vectors[v].memWaits, cycles);
            checkValue({vectors[v].name, " cycles"}, cycles, vectors[v].expCycles);
        end

        for (int n = 0; n < 80; n++) begin
`ifdef ILLEGAL_TRAP_EN
            kind = $urandom_range(K_LW, K_JAL);
`else
            kind = $urandom_range(K_LW, K_ILL);
`endif
            applyStimulus($sformatf("rand%0d", n), randInstr(kind), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $urandom_range(0, 3), cycles);
        end

        // Reset arriving while a load waits on memory must abandon it immediately.
        bus.instr = lwInstr;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 checkOutput("pre_rst_memread", expOut(3, lwInstr, 1'b0, 1'b0));
        #2 rst = 1'b1;
        #1 checkOutput("rst_mid_memread", '0);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1 checkOutput("rst_held", '0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1 checkOutput("post_rst_fetch", expOut(0, lwInstr, 1'b0, 1'b0));
        applyStimulus("lw_after_rst", lwInstr, 1'b0, 0, 0, cycles);
        checkValue("lw_after_rst cycles", cycles, 5);

`ifdef ILLEGAL_TRAP_EN
        applyStimulus("trap_7f", 32'h0000007F, 1'b0, 0, 0, cycles);
        for (int h = 0; h < 20; h++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.EQ = 1'($urandom_range(0, 1));
            #1 checkOutput($sformatf("halt_hold%0d", h), expOut(11, 32'h0000007F, 1'b0, 1'b0));
            @(negedge clk);
        end
        rst = 1'b1;
        #1 checkOutput("halt_reset", '0);
        @(negedge clk);
        rst = 1'b0;
`else
        applyStimulus("nop_7f", 32'h0000007F, 1'b0, 0, 0, cycles);
`endif
        bus.mem_ready = 1'b0;
        #1 checkOutput("final_fetch", expOut(0, 32'h0, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the RV32I-subset datapath: PC, instruction/data memory, regfile, extend, ALU.
- Replaces the single-cycle control unit so that one ALU and one memory port are time-shared across fetch, address, execute and writeback phases.
- A memory ready/request handshake lets fetch and data accesses absorb wait states.
- Sits beside the datapath top and drives every datapath enable and mux select.

Parameters:
- DATA_WIDTH, 32, instruction and datapath width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- instr  in  DATA_WIDTH  instruction register contents (valid from DECODE onward)
- EQ  in  1  ALU zero flag from the current-cycle ALU result
- mem_ready  in  1  memory accepts/completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  store enable, qualified by mem_req
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut register
- IRWrite  out  1  latch fetched word into instruction and OldPC registers
- PCWrite  out  1  PC register enable
- RegWrite  out  1  regfile write enable
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = immOp, 10 = constant 4
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ResultSrc  out  2  00 = ALUOut register, 01 = memory data register, 10 = ALU result
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- state  out  4  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, HALT=11.
- Outputs are combinational from state, instr, EQ and mem_ready. Defaults are all 0. ALUctrl defaults to add.
- Reset: state goes to FETCH immediately when rst rises. While rst=1, every enable and mem_req is forced to 0. The first mem_req is asserted in the first cycle after rst falls.
- Reset during any state, including a pending memory wait, abandons the instruction. No writes occur.

- FETCH:
  - mem_req=1, AdrSrc=0.
  - If mem_ready=0: hold in FETCH with IRWrite=PCWrite=0.
  - If mem_ready=1: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10 (PC+4). Next state is DECODE.
- DECODE:
  - Computes OldPC+imm into ALUOut: ALUSrcA=01, ALUSrcB=01, add.
  - ImmSrc=11 if opcode is jal, else 10.
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other -> illegal.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc=00 for lw, 01 for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD:
  - mem_req=1, AdrSrc=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWRITE:
  - mem_req=1, AdrSrc=1, MemWrite=1, held every cycle until mem_ready=1.
  - Then goes to FETCH.
- EXECR / EXECI:
  - ALUSrcA=10. ALUSrcB=00 for EXECR; 01 with ImmSrc=00 for EXECI.
  - funct3 decoding: 000 add (sub only if EXECR and instr[30]=1); 010 slt; 110 or; 111 and.
  - Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=EQ for funct3 000 (beq); PCWrite=!EQ for funct3 001 (bne).
  - Next state is FETCH.
- JAL:
  - PCWrite=1, ResultSrc=00 (target).
  - ALUSrcA=01, ALUSrcB=10, add (OldPC+4 into ALUOut).
  - Next state is ALUWB.
- Illegal instructions:
  - Any opcode not listed above.
  - funct3 other than 010 for lw/sw.
  - An unlisted funct3 in EXECR/EXECI.
  - Branch funct3 other than 000/001.
  - funct7 other than 0000000/0100000 on R-type.
  - Illegal instructions are detected in DECODE.
- Cycle counts with zero wait states: lw 5, sw 4, R/I ALU 4, branch 3, jal 4. Each cycle with mem_ready=0 adds one cycle.
- mem_ready is ignored in any state where mem_req=0.

Optional Feature:
- ILLEGAL_TRAP_EN
- Defined: an illegal instruction moves DECODE to HALT. HALT holds all outputs at 0 and state=11 until rst.
- Undefined: an illegal instruction returns DECODE to FETCH with no writes (executes as a NOP). HALT is unreachable.

Test Plan:
- addi x5,x0,7 (0x00700293), mem_ready=1 -> states 0,1,7,8,0; RegWrite=1 only in cycle 4, with ALUSrcB=01 and ALUctrl=000 in cycle 3.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> total 10 cycles; IRWrite pulses once; RegWrite pulses once, in MEMWB.
- beq taken (EQ=1) vs not taken (EQ=0) -> PCWrite=1 / 0 in the BRANCH cycle; bne inverts this; both take 3 cycles.
- sw with mem_ready delayed 4 cycles -> MemWrite and mem_req held high all 5 MEMWRITE cycles; RegWrite never asserts.
- rst asserted mid-MEMREAD -> state=0 in the same cycle with all enables 0; after release, FETCH mem_req=1.
- opcode 0x7F: with ILLEGAL_TRAP_EN, state=11 and holds for 20 cycles; without it, returns to FETCH after DECODE with no PCWrite/RegWrite/MemWrite.
